msync_machine_mc: RTL
=====================

// Module: msync_machine_mc
// PURPOSE
//  Multi-channel DAQ-enable sequencer, parametrised successor of the single-channel start/stop latch.
//  Per channel: start/stop-controlled acquisition window, programmable post-stop tail
//  and optional maximum run length. Sits between trigger logic and per-channel ADC capture writers.
// PARAMETERS
//  NCH    4   number of independent channels
//  CNT_W  16  width of post_len / max_len and the internal per-channel counters
// PORTS
//  clk         in   1      system clock; all logic on rising edge
//  reset_n     in   1      synchronous reset, active-low
//  start_daq   in   NCH    per-channel start request, level-sampled each cycle
//  stop_daq    in   NCH    per-channel stop request, level-sampled each cycle
//  disable_ms  in   NCH    per-channel bypass: forces daq_enable[i]=1, does not touch state
//  post_len    in   CNT_W  post-stop tail length in cycles (shared); 0 = stop immediately
//  max_len     in   CNT_W  max RUN length in cycles (shared); 0 = unlimited
//  daq_enable  out  NCH    acquisition enable = (state!=IDLE) | disable_ms (OR is combinational)
//  busy        out  NCH    registered, 1 while state!=IDLE
//  done        out  NCH    1-cycle pulse on any RUN/POST->IDLE transition
//  timeout     out  NCH    1-cycle pulse when RUN ended by max_len
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): all channels IDLE; busy=0, done=0, timeout=0, counters=0;
//    daq_enable = disable_ms only. Reset mid-RUN/POST aborts the window; no done pulse.
//  - Per-channel FSM, channels fully independent. States IDLE, RUN, POST:
//    IDLE: start -> RUN; run_cnt<=0; max_len latched into lim_r. Stop alone ignored.
//    RUN : start has priority. start (with or without stop) -> stay RUN, counter not reset.
//          stop alone -> POST with post_cnt<=post_len-1 if post_len!=0.
//          stop alone with post_len==0 -> IDLE, done pulse.
//          Otherwise, if lim_r!=0 and run_cnt==lim_r-1 -> IDLE, done+timeout pulses.
//          Otherwise run_cnt++.
//    POST: start -> RUN (fresh window: run_cnt<=0, lim_r re-latched).
//          post_cnt==0 -> IDLE, done pulse. Else post_cnt--. Stop ignored.
//  - Latency: start sampled at edge k -> busy/daq_enable high after edge k (1 cycle).
//    Stop at edge e -> enable stays high exactly post_len cycles after e.
//    Timeout window is exactly lim_r cycles high.
//  - post_len sampled only at the stop edge; max_len sampled only at RUN entry. Later changes
//    do not affect the window in progress.
//  - Counters never wrap: run_cnt saturates at all-ones when lim_r==0.
//    lim_r==2^CNT_W-1 is valid.
//  - done and timeout are registered, asserted the cycle after the ending edge, never both
//    from a stop.
// CONFIGURATION
//  MSYNC_MAXLEN_EN defined: max_len/timeout behaviour as above.
//  Not defined: max_len port present but ignored, RUN ends only on stop, timeout tied 0,
//    lim_r and run_cnt not synthesised.
// TESTING
//  1 reset_n=0 3 cycles, all inputs 0 -> daq_enable=0,busy=0,done=0; disable_ms=4'b0101 -> daq_enable=4'b0101.
//  2 post_len=0: start[0] @t, stop[0] @t+10 -> enable[0] high cycles t+1..t+10 (10 cycles), done[0] @t+11.
//  3 post_len=5: start[1], stop[1] after 8 cyc -> enable high 8+5 cycles; post_len->9 mid-POST has no effect.
//  4 MSYNC_MAXLEN_EN, max_len=20, start[2], no stop -> enable high 20 cycles, done[2]=timeout[2]=1 one cycle.
//  5 start&stop same cycle in IDLE and in RUN -> channel enters/stays RUN.
//    start during POST -> restarts RUN, no done pulse.
//  6 reset_n=0 mid-POST on ch3 while ch0 RUN -> both IDLE next cycle, no done; without macro timeout stays 0.

Source files
------------

// File: rtl/msync_machine_mc.sv
// Multi-channel DAQ-enable sequencer: per-channel start/stop window with post-stop tail.
// Define MSYNC_MAXLEN_EN to enable the max_len run-length limit and the timeout pulse.
module msync_machine_mc #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCH-1:0]   start_daq,
    input  logic [NCH-1:0]   stop_daq,
    input  logic [NCH-1:0]   disable_ms,
    input  logic [CNT_W-1:0] post_len,
    input  logic [CNT_W-1:0] max_len,
    output logic [NCH-1:0]   daq_enable,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   done,
    output logic [NCH-1:0]   timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_POST = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state_r       [NCH];
    state_t           state_nx_s    [NCH];
    logic [CNT_W-1:0] post_cnt_r    [NCH];
    logic [CNT_W-1:0] post_cnt_nx_s [NCH];
    logic [NCH-1:0]   busy_r;
    logic [NCH-1:0]   busy_nx_s;
    logic [NCH-1:0]   done_r;
    logic [NCH-1:0]   done_nx_s;

`ifdef MSYNC_MAXLEN_EN
    logic [CNT_W-1:0] run_cnt_r     [NCH];
    logic [CNT_W-1:0] run_cnt_nx_s  [NCH];
    logic [CNT_W-1:0] lim_r         [NCH];
    logic [CNT_W-1:0] lim_nx_s      [NCH];
    logic [NCH-1:0]   timeout_r;
    logic [NCH-1:0]   timeout_nx_s;
`else
    logic             unused_max_len_s;
    assign unused_max_len_s = ^max_len;
`endif

    // Per-channel next-state, counter updates and end-of-window pulses
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_nx_s[i]    = state_r[i];
            post_cnt_nx_s[i] = post_cnt_r[i];
            done_nx_s[i]     = 1'b0;
`ifdef MSYNC_MAXLEN_EN
            run_cnt_nx_s[i]  = run_cnt_r[i];
            lim_nx_s[i]      = lim_r[i];
            timeout_nx_s[i]  = 1'b0;
`endif
            case (state_r[i])
                ST_IDLE: begin
                    if (start_daq[i]) begin
                        state_nx_s[i]   = ST_RUN;
`ifdef MSYNC_MAXLEN_EN
                        run_cnt_nx_s[i] = '0;
                        lim_nx_s[i]     = max_len;
`endif
                    end else begin
                        state_nx_s[i] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start wins over stop and holds the run counter
                    if (start_daq[i]) begin
                        state_nx_s[i] = ST_RUN;
                    end else if (stop_daq[i]) begin
                        if (post_len != '0) begin
                            state_nx_s[i]    = ST_POST;
                            post_cnt_nx_s[i] = post_len - ONE_C;
                        end else begin
                            state_nx_s[i] = ST_IDLE;
                            done_nx_s[i]  = 1'b1;
                        end
                    end
`ifdef MSYNC_MAXLEN_EN
                    else if ((lim_r[i] != '0) && (run_cnt_r[i] == (lim_r[i] - ONE_C))) begin
                        state_nx_s[i]   = ST_IDLE;
                        done_nx_s[i]    = 1'b1;
                        timeout_nx_s[i] = 1'b1;
                    end else if (run_cnt_r[i] != '1) begin
                        run_cnt_nx_s[i] = run_cnt_r[i] + ONE_C;
                    end else begin
                        run_cnt_nx_s[i] = run_cnt_r[i];
                    end
`else
                    else begin
                        state_nx_s[i] = ST_RUN;
                    end
`endif
                end
                ST_POST: begin
                    if (start_daq[i]) begin
                        state_nx_s[i]   = ST_RUN;
`ifdef MSYNC_MAXLEN_EN
                        run_cnt_nx_s[i] = '0;
                        lim_nx_s[i]     = max_len;
`endif
                    end else if (post_cnt_r[i] == '0) begin
                        state_nx_s[i] = ST_IDLE;
                        done_nx_s[i]  = 1'b1;
                    end else begin
                        post_cnt_nx_s[i] = post_cnt_r[i] - ONE_C;
                    end
                end
                default: begin
                    state_nx_s[i] = ST_IDLE;
                end
            endcase
            busy_nx_s[i] = (state_nx_s[i] != ST_IDLE);
        end
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i]    <= ST_IDLE;
                post_cnt_r[i] <= '0;
`ifdef MSYNC_MAXLEN_EN
                run_cnt_r[i]  <= '0;
                lim_r[i]      <= '0;
`endif
            end
            busy_r    <= '0;
            done_r    <= '0;
`ifdef MSYNC_MAXLEN_EN
            timeout_r <= '0;
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i]    <= state_nx_s[i];
                post_cnt_r[i] <= post_cnt_nx_s[i];
`ifdef MSYNC_MAXLEN_EN
                run_cnt_r[i]  <= run_cnt_nx_s[i];
                lim_r[i]      <= lim_nx_s[i];
`endif
            end
            busy_r    <= busy_nx_s;
            done_r    <= done_nx_s;
`ifdef MSYNC_MAXLEN_EN
            timeout_r <= timeout_nx_s;
`endif
        end
    end

    // Bypass is combinational so disable_ms acts immediately, even in reset
    assign daq_enable = busy_r | disable_ms;
    assign busy       = busy_r;
    assign done       = done_r;
`ifdef MSYNC_MAXLEN_EN
    assign timeout    = timeout_r;
`else
    assign timeout    = {NCH{1'b0}};
`endif

endmodule
